// File: rtl/reg_pkg.sv
// Shared definitions for the register-layer readout engine:
// the readout FSM state encoding and the default captured word width.
package reg_pkg;

    localparam int REG_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } readout_state_t;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter with decrement enable and zero flag.
// Saturates at zero, so a caller that stops decrementing on zero never
// sees a wrap. Intended for bit counting in serial shifters.
module bit_down_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          zero_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Load takes priority over decrement; decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/reg_readout_ser.sv
// Serial readout engine: captures a parallel register word and shifts it
// out MSB first, one bit per accepted beat over ser_valid/ser_ready.
// Optional feature macro: REG_READOUT_PARITY_EN appends one even-parity
// beat after the data bits; that beat then carries ser_last.
//
// Handshake: a beat completes on a rising edge where ser_valid, ser_ready
// and en are all high. ser_valid depends only on registered state, so the
// consumer may wait on it freely; ser_ready is never combinationally
// reflected on any output. en = 0 freezes everything except DONE->IDLE.
module reg_readout_ser
    import reg_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load_req,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     ready,
    output logic                     ser_out,
    output logic                     ser_valid,
    input  logic                     ser_ready,
    output logic                     ser_last,
    output logic                     done,
    output readout_state_t           dbg_state,
    output logic [$clog2(WIDTH)-1:0] dbg_bitcnt
);

    // Width of the bit counter; WIDTH is expected to be 8 or 16.
    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    readout_state_t state_q;
    readout_state_t state_d;

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    logic [CW-1:0] bitcnt;
    logic          bitcnt_zero;

    logic load_fire;
    logic beat_fire;
    logic shift_beat;

`ifdef REG_READOUT_PARITY_EN
    logic par_q;
    logic par_d;
`endif

    assign load_fire  = (state_q == IDLE) && load_req && en;
    assign beat_fire  = ser_valid && ser_ready && en;
    assign shift_beat = beat_fire && (state_q == SHIFT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always returns to IDLE regardless of en.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_beat && bitcnt_zero) begin
`ifdef REG_READOUT_PARITY_EN
                    state_d = PAR;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef REG_READOUT_PARITY_EN
            PAR: begin
                if (beat_fire) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        done      = 1'b0;
        case (state_q)
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg_q[WIDTH-1];
`ifndef REG_READOUT_PARITY_EN
                ser_last  = bitcnt_zero;
`endif
            end
`ifdef REG_READOUT_PARITY_EN
            PAR: begin
                ser_valid = 1'b1;
                ser_out   = par_q;
                ser_last  = 1'b1;
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            default: begin
                ser_valid = 1'b0;
            end
        endcase
    end

    // Shift register: capture on load, shift left with zero fill per data beat.
    always_comb begin
        shreg_d = shreg_q;
        if (load_fire) begin
            shreg_d = data_in;
        end else if (shift_beat) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

`ifdef REG_READOUT_PARITY_EN
    // Even-parity bit of the captured word, computed once at load.
    always_comb begin
        par_d = par_q;
        if (load_fire) begin
            par_d = ^data_in;
        end
    end

    // Parity storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // Bit counter: loaded with WIDTH-1 at capture, decremented per data beat.
    bit_down_counter #(
        .CW (CW)
    ) u_bitcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_fire),
        .load_val_i (CNT_MAX),
        .dec_i      (shift_beat),
        .count_o    (bitcnt),
        .zero_o     (bitcnt_zero)
    );

    assign ready      = (state_q == IDLE);
    assign dbg_state  = state_q;
    assign dbg_bitcnt = bitcnt;

endmodule

// File: tb/tb_reg_readout_ser.sv
// Directed bench for reg_readout_ser: 16-bit and 8-bit instances,
// table of word transfers plus hand-written reset and back-to-back sequences.
module tb_reg_readout_ser;

`ifdef REG_READOUT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance signals
    logic        load_req = 1'b0;
    logic [15:0] data_in = '0;
    logic        ser_ready = 1'b0;
    logic        ready, ser_out, ser_valid, ser_last, done;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_bitcnt;

    // 8-bit instance signals
    logic        load_req_8 = 1'b0;
    logic [7:0]  data_in_8 = '0;
    logic        ser_ready_8 = 1'b0;
    logic        ready_8, ser_out_8, ser_valid_8, ser_last_8, done_8;
    logic [1:0]  dbg_state_8;
    logic [2:0]  dbg_bitcnt_8;

    reg_readout_ser #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .en(en), .load_req(load_req), .data_in(data_in),
        .ready(ready), .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .ser_last(ser_last), .done(done), .dbg_state(dbg_state), .dbg_bitcnt(dbg_bitcnt)
    );

    reg_readout_ser #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .en(en), .load_req(load_req_8), .data_in(data_in_8),
        .ready(ready_8), .ser_out(ser_out_8), .ser_valid(ser_valid_8), .ser_ready(ser_ready_8),
        .ser_last(ser_last_8), .done(done_8), .dbg_state(dbg_state_8), .dbg_bitcnt(dbg_bitcnt_8)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] data;
        logic        par;        // hand-computed even parity of data
        int          stall_beat; // beat index before which the stall is inserted (-1 none)
        int          stall_n;
        logic        stall_en;   // 1: stall with en=0, 0: stall with ser_ready=0
        int          spur_beat;  // beat where a stray load of FFFF is pulsed (-1 none)
    } vec_t;

    vec_t vecs[7];

    // One full 16-bit transfer with optional stall and stray load.
    task automatic send16(input vec_t v, input string tag);
        int   nb;
        int   cyc;
        int   stalls;
        logic eb;
        nb = 16 + PB;
        cyc = 0;
        stalls = 0;
        @(negedge clk);
        en = 1'b1; ser_ready = 1'b1; load_req = 1'b1; data_in = v.data;
        chk({tag, " ready_idle"}, 32'(ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        load_req = 1'b0;
        data_in = 16'($urandom_range(0, 65535));
        for (int k = 0; k < nb; k++) begin
            if (k < 16) eb = v.data[15-k];
            else        eb = v.par;
            if (k == v.stall_beat) begin
                for (int s = 0; s < v.stall_n; s++) begin
                    if (v.stall_en) en = 1'b0;
                    else            ser_ready = 1'b0;
                    chk($sformatf("%s stall%0d valid", tag, s), 32'(ser_valid), 32'd1);
                    chk($sformatf("%s stall%0d out", tag, s), 32'(ser_out), 32'(eb));
                    if (k < 16) begin
                        chk($sformatf("%s stall%0d bitcnt", tag, s), 32'(dbg_bitcnt), 32'(15 - k));
                        chk($sformatf("%s stall%0d state", tag, s), 32'(dbg_state), 32'(ST_SHIFT));
                    end
                    @(posedge clk);
                    cyc++;
                    stalls++;
                    @(negedge clk);
                end
            end
            en = 1'b1;
            ser_ready = 1'b1;
            if (k == v.spur_beat) begin
                load_req = 1'b1;
                data_in = 16'hFFFF;
            end else begin
                load_req = 1'b0;
            end
            chk($sformatf("%s beat%0d valid", tag, k), 32'(ser_valid), 32'd1);
            chk($sformatf("%s beat%0d out", tag, k), 32'(ser_out), 32'(eb));
            chk($sformatf("%s beat%0d last", tag, k), 32'(ser_last), 32'(k == nb - 1));
            chk($sformatf("%s beat%0d ready", tag, k), 32'(ready), 32'd0);
            if (k < 16) begin
                chk($sformatf("%s beat%0d bitcnt", tag, k), 32'(dbg_bitcnt), 32'(15 - k));
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        load_req = 1'b0;
        chk({tag, " done_pulse"}, 32'(done), 32'd1);
        chk({tag, " done_valid"}, 32'(ser_valid), 32'd0);
        chk({tag, " done_timing"}, 32'(cyc), 32'(nb + stalls));
        @(posedge clk);
        @(negedge clk);
        chk({tag, " done_clear"}, 32'(done), 32'd0);
        chk({tag, " ready_back"}, 32'(ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{16'hA5C3, 1'b0, -1, 0, 1'b0, -1};
        vecs[1] = '{16'h0001, 1'b1, -1, 0, 1'b0, -1};
        vecs[2] = '{16'hA5C3, 1'b0,  4, 3, 1'b0, -1};  // backpressure after beat 4
        vecs[3] = '{16'h1234, 1'b1,  6, 5, 1'b1, -1};  // en dropped 5 cycles
        vecs[4] = '{16'hA5C3, 1'b0, -1, 0, 1'b0,  3};  // stray load FFFF during SHIFT
        vecs[5] = '{16'hFFFF, 1'b0, -1, 0, 1'b0, -1};
        vecs[6] = '{16'h0F0E, 1'b1, -1, 0, 1'b0, 10};

        // reset state
        #12;
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst valid", 32'(ser_valid), 32'd0);
        chk("rst out", 32'(ser_out), 32'd0);
        chk("rst last", 32'(ser_last), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst ready_8", 32'(ready_8), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send16(vecs[i], $sformatf("v%0d", i));
        end

        // mid-word reset: abort after 7 accepted beats
        @(negedge clk);
        ser_ready = 1'b1; load_req = 1'b1; data_in = 16'hA5C3;
        @(posedge clk);
        @(negedge clk);
        load_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid bitcnt_before", 32'(dbg_bitcnt), 32'd8);
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", 32'(ser_valid), 32'd0);
        chk("mid rst out", 32'(ser_out), 32'd0);
        chk("mid rst last", 32'(ser_last), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        chk("mid rst ready", 32'(ready), 32'd1);
        chk("mid rst state", 32'(dbg_state), 32'(ST_IDLE));
        chk("mid rst bitcnt", 32'(dbg_bitcnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send16('{16'h8000, 1'b1, -1, 0, 1'b0, -1}, "post_rst");

        // 8-bit instance: single word 3C
        @(negedge clk);
        ser_ready_8 = 1'b1; load_req_8 = 1'b1; data_in_8 = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        load_req_8 = 1'b0;
        begin
            logic [7:0] w8;
            logic       eb8;
            w8 = 8'h3C;
            for (int k = 0; k < 8 + PB; k++) begin
                if (k < 8) eb8 = w8[7-k];
                else       eb8 = 1'b0;  // 3C has four ones
                chk($sformatf("w8 beat%0d valid", k), 32'(ser_valid_8), 32'd1);
                chk($sformatf("w8 beat%0d out", k), 32'(ser_out_8), 32'(eb8));
                chk($sformatf("w8 beat%0d last", k), 32'(ser_last_8), 32'(k == 8 + PB - 1));
                @(posedge clk);
                @(negedge clk);
            end
        end
        chk("w8 done", 32'(done_8), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("w8 ready_back", 32'(ready_8), 32'd1);

        // 8-bit back-to-back: load_req held high, measure spacing of idle cycles
        begin
            int hits[$];
            load_req_8 = 1'b1;
            data_in_8 = 8'h5A;
            hits.push_back(0);
            for (int i = 1; i <= 40 && hits.size() < 3; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (ready_8) hits.push_back(i);
            end
            if (hits.size() < 3) begin
                chk("b2b idle_count", 32'(hits.size()), 32'd3);
            end else begin
                chk("b2b gap1", 32'(hits[1] - hits[0]), 32'(10 + PB));
                chk("b2b gap2", 32'(hits[2] - hits[1]), 32'(10 + PB));
            end
            load_req_8 = 1'b0;
            for (int i = 0; i < 14; i++) begin
                @(posedge clk);
            end
            @(negedge clk);
            chk("b2b final idle", 32'(ready_8), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
